// File: rtl/wireframe_raster.sv
// rtl/wireframe_raster.sv - Bresenham wireframe rasteriser for triangle edges into a 1-bit SRAM.
// ver packing: {p.x,p.y,p.z, q.x,q.y,q.z, r.x,r.y,r.z}, 16 bits each, p.x in ver[143:128].
module wireframe_raster #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int ADDR_BITS = 19
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 clr,
    input  logic [143:0]         ver,
    output logic                 ready,
    output logic                 done,
    output logic                 wf_we,
    output logic [ADDR_BITS-1:0] wf_addr,
    output logic                 wf_wdata
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETUP, S_STEP, S_DONE} state_t;

    localparam logic [ADDR_BITS-1:0] LAST_A  = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] WIDTH_A = ADDR_BITS'(WIDTH);
    localparam logic signed [15:0]   WIDTH_S = 16'(WIDTH);
    localparam logic signed [15:0]   HEIGHT_S = 16'(HEIGHT);

    state_t state_q, state_d;
    logic signed [15:0] px_q, py_q, qx_q, qy_q, rx_q, ry_q;
    logic signed [15:0] px_d, py_d, qx_d, qy_d, rx_d, ry_d;
    logic [1:0]  k_q, k_d;
    logic signed [15:0] x_q, y_q, ex_q, ey_q, x_d, y_d, ex_d, ey_d;
    logic signed [17:0] dx_q, dy_q, err_q, dx_d, dy_d, err_d;
    logic sx_q, sy_q, sx_d, sy_d;
    logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
    logic wf_we_q, wf_we_d, wf_wdata_q, wf_wdata_d;
    logic [ADDR_BITS-1:0] wf_addr_q, wf_addr_d;

    logic signed [15:0] x0, y0, x1, y1;
    logic signed [17:0] ddx, ddy, adx, ady, e2;
    logic [ADDR_BITS-1:0] pix_addr;
    logic in_range;

    always_comb begin
        case (k_q)
            2'd0:    begin x0 = px_q; y0 = py_q; x1 = qx_q; y1 = qy_q; end
            2'd1:    begin x0 = qx_q; y0 = qy_q; x1 = rx_q; y1 = ry_q; end
            default: begin x0 = rx_q; y0 = ry_q; x1 = px_q; y1 = py_q; end
        endcase
        ddx = 18'(x1) - 18'(x0);
        ddy = 18'(y1) - 18'(y0);
        adx = ddx[17] ? -ddx : ddx;
        ady = ddy[17] ? -ddy : ddy;
        e2  = err_q <<< 1;
        pix_addr = ADDR_BITS'($unsigned(y_q)) * WIDTH_A + ADDR_BITS'($unsigned(x_q));
        in_range = !x_q[15] && (x_q < WIDTH_S) && !y_q[15] && (y_q < HEIGHT_S);
    end

    always_comb begin
        state_d = state_q;
        px_d = px_q; py_d = py_q; qx_d = qx_q; qy_d = qy_q; rx_d = rx_q; ry_d = ry_q;
        k_d = k_q;
        x_d = x_q; y_d = y_q; ex_d = ex_q; ey_d = ey_q;
        dx_d = dx_q; dy_d = dy_q; err_d = err_q; sx_d = sx_q; sy_d = sy_q;
        clr_addr_d = clr_addr_q;
        wf_we_d    = 1'b0;
        wf_addr_d  = wf_addr_q;
        wf_wdata_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    px_d = ver[143:128]; py_d = ver[127:112];
                    qx_d = ver[95:80];   qy_d = ver[79:64];
                    rx_d = ver[47:32];   ry_d = ver[31:16];
                    k_d  = 2'd0;
                    clr_addr_d = '0;
                    state_d = clr ? S_CLEAR : S_SETUP;
                end
            end
            S_CLEAR: begin
                wf_we_d   = 1'b1;
                wf_addr_d = clr_addr_q;
                if (clr_addr_q == LAST_A) state_d = S_SETUP;
                else clr_addr_d = clr_addr_q + 1'b1;
            end
            S_SETUP: begin
                x_d = x0; y_d = y0; ex_d = x1; ey_d = y1;
                dx_d  = adx;
                dy_d  = -ady;
                sx_d  = ddx[17];
                sy_d  = ddy[17];
                err_d = adx - ady;
                state_d = S_STEP;
            end
            S_STEP: begin
                // Off-screen pixels still take their cycle so timing is independent of clipping.
                wf_we_d    = in_range;
                wf_addr_d  = pix_addr;
                wf_wdata_d = 1'b1;
                if (x_q == ex_q && y_q == ey_q) begin
                    if (k_q == 2'd2) state_d = S_DONE;
                    else begin
                        k_d = k_q + 2'd1;
                        state_d = S_SETUP;
                    end
                end else begin
                    err_d = err_q + ((e2 >= dy_q) ? dy_q : 18'sd0) + ((e2 <= dx_q) ? dx_q : 18'sd0);
                    if (e2 >= dy_q) x_d = x_q + (sx_q ? -16'sd1 : 16'sd1);
                    if (e2 <= dx_q) y_d = y_q + (sy_q ? -16'sd1 : 16'sd1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            px_q <= '0; py_q <= '0; qx_q <= '0; qy_q <= '0; rx_q <= '0; ry_q <= '0;
            k_q <= '0;
            x_q <= '0; y_q <= '0; ex_q <= '0; ey_q <= '0;
            dx_q <= '0; dy_q <= '0; err_q <= '0; sx_q <= 1'b0; sy_q <= 1'b0;
            clr_addr_q <= '0;
            wf_we_q <= 1'b0; wf_addr_q <= '0; wf_wdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q <= px_d; py_q <= py_d; qx_q <= qx_d; qy_q <= qy_d; rx_q <= rx_d; ry_q <= ry_d;
            k_q <= k_d;
            x_q <= x_d; y_q <= y_d; ex_q <= ex_d; ey_q <= ey_d;
            dx_q <= dx_d; dy_q <= dy_d; err_q <= err_d; sx_q <= sx_d; sy_q <= sy_d;
            clr_addr_q <= clr_addr_d;
            wf_we_q <= wf_we_d; wf_addr_q <= wf_addr_d; wf_wdata_q <= wf_wdata_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign wf_we    = wf_we_q;
    assign wf_addr  = wf_addr_q;
    assign wf_wdata = wf_wdata_q;
endmodule

// File: tb/tb_wireframe_raster.sv
// tb/tb_wireframe_raster.sv - Directed and random triangles checked against a Bresenham reference.
module tb_wireframe_raster;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AB = 5;

    logic          clk = 1'b0;
    logic          n_rst, start, clr;
    logic [143:0]  ver;
    logic          ready, done, wf_we, wf_wdata;
    logic [AB-1:0] wf_addr;

    int total = 0;
    int bad   = 0;
    int cap_a[$], cap_d[$], exp_a[$], exp_d[$];

    wireframe_raster #(.WIDTH(W), .HEIGHT(H), .ADDR_BITS(AB)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .clr(clr), .ver(ver),
        .ready(ready), .done(done), .wf_we(wf_we), .wf_addr(wf_addr), .wf_wdata(wf_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wf_we === 1'b1) begin
            cap_a.push_back(int'(wf_addr));
            cap_d.push_back(int'(wf_wdata));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] pack6(input int ax, ay, bx, by, cx, cy);
        return {16'(ax), 16'(ay), 16'($urandom), 16'(bx), 16'(by), 16'($urandom),
                16'(cx), 16'(cy), 16'($urandom)};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: expected write list and start->done cycle count straight from the drawing rules.
    task automatic model(input int vx[3], input int vy[3], input bit c, output int cyc);
        exp_a.delete(); exp_d.delete();
        cyc = 1;
        if (c) begin
            for (int a = 0; a < W * H; a++) begin exp_a.push_back(a); exp_d.push_back(0); end
            cyc += W * H;
        end
        for (int e = 0; e < 3; e++) begin
            int x, y, x1, y1, dx, dy, sx, sy, err, e2;
            x = vx[e]; y = vy[e]; x1 = vx[(e + 1) % 3]; y1 = vy[(e + 1) % 3];
            dx = iabs(x1 - x); dy = -iabs(y1 - y);
            sx = (x1 < x) ? -1 : 1; sy = (y1 < y) ? -1 : 1;
            err = dx + dy;
            cyc += 2 + ((dx > -dy) ? dx : -dy);
            forever begin
                if (x >= 0 && x < W && y >= 0 && y < H) begin
                    exp_a.push_back(y * W + x); exp_d.push_back(1);
                end
                if (x == x1 && y == y1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end
    endtask

    task automatic run_tri(input string nm, input int ax, ay, bx, by, cx, cy,
                           input bit c, input int glitch_at, input int rst_at);
        int vx[3], vy[3];
        int cyc, n, got, rdy_hi, nw;
        vx[0] = ax; vy[0] = ay; vx[1] = bx; vy[1] = by; vx[2] = cx; vy[2] = cy;
        model(vx, vy, c, cyc);
        cap_a.delete(); cap_d.delete();
        @(negedge clk);
        ver = pack6(ax, ay, bx, by, cx, cy); clr = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ver = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)}; clr = 1'($urandom);
        n = 1; got = 0; rdy_hi = 0;
        while (n <= cyc + 20) begin
            if (n == rst_at) begin
                n_rst = 1'b0;
                #1;
                check({nm, " rst we"}, int'(wf_we), 0);
                check({nm, " rst ready"}, int'(ready), 1);
                check({nm, " rst addr"}, int'(wf_addr), 0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check({nm, " rst done"}, int'(done), 0);
                end
                n_rst = 1'b1;
                return;
            end
            if (done === 1'b1) begin got = 1; break; end
            if (ready !== 1'b0) rdy_hi = 1;
            if (n == glitch_at) begin
                start = 1'b1; ver = pack6(1, 1, 5, 3, 7, 0);
            end else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({nm, " done seen"}, got, 1);
        check({nm, " cycles"}, n, cyc);
        check({nm, " ready low"}, rdy_hi, 0);
        @(negedge clk);
        check({nm, " done pulse"}, int'(done), 0);
        check({nm, " ready back"}, int'(ready), 1);
        check({nm, " nwrites"}, cap_a.size(), exp_a.size());
        nw = (cap_a.size() < exp_a.size()) ? cap_a.size() : exp_a.size();
        for (int i = 0; i < nw; i++) begin
            check($sformatf("%s w%0d addr", nm, i), cap_a[i], exp_a[i]);
            check($sformatf("%s w%0d data", nm, i), cap_d[i], exp_d[i]);
        end
    endtask

    initial begin
        int t1[12];
        t1 = '{0, 1, 2, 3, 3, 10, 17, 24, 24, 16, 8, 0};
        n_rst = 1'b0; start = 1'b0; clr = 1'b0; ver = '0;
        repeat (2) @(negedge clk);
        check("reset ready", int'(ready), 1);
        check("reset done", int'(done), 0);
        check("reset we", int'(wf_we), 0);
        check("reset addr", int'(wf_addr), 0);
        check("reset wdata", int'(wf_wdata), 0);
        n_rst = 1'b1;
        @(negedge clk);

        run_tri("T1", 0, 0, 3, 0, 0, 3, 1'b0, 0, 0);
        check("T1 count", cap_a.size(), 12);
        for (int i = 0; i < 12 && i < cap_a.size(); i++)
            check($sformatf("T1 seq%0d", i), cap_a[i], t1[i]);
        run_tri("T2", 0, 0, 3, 0, 0, 3, 1'b1, 0, 0);
        run_tri("T3", 6, 1, 10, 1, 6, 1, 1'b0, 0, 0);
        run_tri("T4", 2, 2, 2, 2, 2, 2, 1'b0, 0, 0);
        check("T4 count", cap_a.size(), 3);
        run_tri("T5", 0, 0, 3, 0, 0, 3, 1'b0, 9, 0);
        run_tri("T6", 0, 0, 3, 0, 0, 3, 1'b0, 0, 8);
        run_tri("T6b", 0, 0, 3, 0, 0, 3, 1'b0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            run_tri($sformatf("R%0d", t),
                    int'($urandom_range(0, 14)) - 3, int'($urandom_range(0, 10)) - 3,
                    int'($urandom_range(0, 14)) - 3, int'($urandom_range(0, 10)) - 3,
                    int'($urandom_range(0, 14)) - 3, int'($urandom_range(0, 10)) - 3,
                    ($urandom_range(0, 3) == 0), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
